alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Hardwired control sequencer that drives the datapath's bus-select, register-enable, memory-read and ALU-operation controls for three-operand register ALU instructions. It sits directly upstream of the datapath and replaces the hand-driven T0–T5 stimulus with a real fetch/decode/execute FSM. It reads the datapath IR, waits on a memory-ready handshake during fetch, and halts with a sticky flag on an illegal opcode or a memory timeout.

## Interface
- MEM_TIMEOUT, 15: maximum number of wait cycles in fetch before a memory fault (1–15).
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- run  in  1  level; 1 = fetch and execute instructions, 0 = stop after the current instruction.
- IR  in  32  datapath IR contents; opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
- mem_ready  in  1  memory data valid on in_memory_data this cycle.
- PCout, ZLowout, ZHighout, MDRout, Rout  out  1 each  bus drive enables.
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin  out  1 each  register load enables.
- read  out  1  memory read strobe.
- ALU_operation  out  4  ADD=0, SUB=1, AND=2, OR=3, NEG=4, NOT=5, SHR=6, SHRA=7, SHL=8, ROR=9, ROL=10, MUL=11, DIV=12, IncPC=13, NONE=14.
- reg_select  out  4  general-register index for Rin/Rout.
- busy  out  1  high in every state except IDLE and HALT.
- instr_done  out  1  one-cycle pulse in the final T-state of each instruction.
- illegal  out  1  sticky; illegal opcode seen.
- mem_fault  out  1  sticky; fetch timeout.

## Operation
- Moore outputs decode from the registered state. The ALU_operation and reg_select outputs in T3–T6 also decode IR fields. Outputs that are not listed for a state are 0; ALU_operation defaults to NONE and reg_select defaults to 0.
- IDLE: if run=1, go to T0.
- T0: PCout, MARin, Zin, ALU_operation=IncPC. Go to T1.
- T1: ZLowout, PCin, read, MDRin. Go to T2 if mem_ready=1, else go to T1W and load wait_cnt=1.
- T1W: read, MDRin. Go to T2 if mem_ready=1. Otherwise, go to HALT and set mem_fault when wait_cnt=MEM_TIMEOUT, else increment wait_cnt. PCin is never repeated in this state.
- T2: MDRout, IRin. Go to T3. The IR opcode is evaluated in T3.
- T3: if opcode>12, go to HALT and set illegal; no other outputs are asserted. Otherwise assert Rout, reg_select=rb, Yin, and go to T4.
- T4: Rout, Zin, ALU_operation=opcode. reg_select=rc, except for NEG and NOT (unary), where reg_select=rb. Go to T5.
- T5, for opcodes other than MUL and DIV: ZLowout, Rin, reg_select=ra, instr_done. Go to T0 if run=1, else go to IDLE.
- T5, for MUL and DIV: ZLowout, LOin. Go to T6.
- T6: ZHighout, HIin, instr_done. The next state is the same as after an ordinary T5.
- HALT: all control outputs are 0 and busy=0. The state is held until clear.
- run=0 is sampled only in IDLE and at the last T-state. Dropping run mid-instruction does not abort the instruction.

## Timing
- Reset values: state=IDLE, wait_cnt=0, every enable and strobe 0, ALU_operation=NONE, reg_select=0, busy=0, instr_done=0, illegal=0, mem_fault=0.
- clear is asynchronous: asserting it in any state forces reset values immediately, without waiting for a clock edge. The first T0 occurs on the first rising edge with clear=0 and run=1.
- Instruction latency with mem_ready=1 in T1: 6 cycles (T0–T5), or 7 cycles for MUL/DIV. Each T1W cycle adds 1 cycle.
- mem_ready is sampled on the rising edge that ends T1/T1W; data is captured into MDR on that same edge.
- Timeout boundary: with MEM_TIMEOUT=15, mem_ready=1 arriving in the 15th T1W cycle succeeds; no mem_ready by the end of that cycle means HALT.
- Back-to-back instructions: the cycle after the last T-state is T0, with no bubble.
- illegal and mem_fault are exclusive: the first fault wins and the state is frozen.

## Test plan
- Reset: clear=1 mid-T4 -> all outputs return to their reset values within the same cycle, ALU_operation=14, busy=0. After release, run=1 -> T0 on the next edge.
- AND: R5=0x34, R6=0x45, IR=0x112B0000, mem_ready=1 -> reg_select sequence 5,6,2; ALU_operation=2 in T4; R2=0x04; instr_done 6 cycles after T0.
- SUB with 3 wait cycles: IR=0x092B0000 -> T1W held for 3 cycles, PCin asserted exactly once, R2=0xFFFFFFEF, latency 9 cycles.
- MUL: IR=0x582B0000 -> T5 asserts LOin and ZLowout, T6 asserts HIin and ZHighout; LO=0x00000E04, HI=0; Rin never asserted.
- Illegal opcode: IR=0xF8000000 -> HALT entered on the edge after T3; illegal=1 sticky; busy=0; run toggling has no effect until clear.
- Timeout: mem_ready=0 held -> mem_fault=1 after T1 plus 15 T1W cycles; illegal stays 0.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for three-operand register ALU instructions.
// Drives datapath bus selects, register loads, memory read and ALU operation from a Moore FSM.
module alu_control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        HIin,
    output logic        LOin,
    output logic        read,
    output logic [3:0]  ALU_operation,
    output logic [3:0]  reg_select,
    output logic        busy,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_fault
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT1W, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    localparam logic [3:0] OpNeg      = 4'd4;
    localparam logic [3:0] OpNot      = 4'd5;
    localparam logic [3:0] OpMul      = 4'd11;
    localparam logic [3:0] OpDiv      = 4'd12;
    localparam logic [3:0] OpIncPc    = 4'd13;
    localparam logic [3:0] OpNone     = 4'd14;
    localparam logic [3:0] TimeoutCnt = 4'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       mem_fault_q, mem_fault_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_legal, op_muldiv, op_unary;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign op_legal  = (opcode <= 5'd12);
    assign op_muldiv = (opcode[3:0] == OpMul) || (opcode[3:0] == OpDiv);
    assign op_unary  = (opcode[3:0] == OpNeg) || (opcode[3:0] == OpNot);
    assign unused_ir = ^IR[14:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            illegal_q   <= illegal_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        illegal_d   = illegal_q;
        mem_fault_d = mem_fault_q;
        unique case (state_q)
            StIdle: if (run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1: begin
                if (mem_ready) begin
                    state_d = StT2;
                end else begin
                    state_d    = StT1W;
                    wait_cnt_d = 4'd1;
                end
            end
            StT1W: begin
                if (mem_ready) begin
                    state_d = StT2;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    state_d     = StHalt;
                    mem_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StT2:   state_d = StT3;
            StT3: begin
                if (op_legal) begin
                    state_d = StT4;
                end else begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StT4:   state_d = StT5;
            StT5: begin
                if (op_muldiv) state_d = StT6;
                else           state_d = run ? StT0 : StIdle;
            end
            StT6:   state_d = run ? StT0 : StIdle;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Moore decode: every output is a function of the registered state and the stable IR.
    always_comb begin
        PCout         = 1'b0;
        ZLowout       = 1'b0;
        ZHighout      = 1'b0;
        MDRout        = 1'b0;
        Rout          = 1'b0;
        PCin          = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        IRin          = 1'b0;
        Yin           = 1'b0;
        Zin           = 1'b0;
        Rin           = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        read          = 1'b0;
        ALU_operation = OpNone;
        reg_select    = 4'd0;
        instr_done    = 1'b0;
        unique case (state_q)
            StT0: begin
                PCout         = 1'b1;
                MARin         = 1'b1;
                Zin           = 1'b1;
                ALU_operation = OpIncPc;
            end
            StT1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT1W: begin
                read  = 1'b1;
                MDRin = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                if (op_legal) begin
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    reg_select = rb;
                end
            end
            StT4: begin
                Rout          = 1'b1;
                Zin           = 1'b1;
                ALU_operation = opcode[3:0];
                reg_select    = op_unary ? rb : rc;
            end
            StT5: begin
                ZLowout = 1'b1;
                if (op_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin        = 1'b1;
                    reg_select = ra;
                    instr_done = 1'b1;
                end
            end
            StT6: begin
                ZHighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle) && (state_q != StHalt);
    assign illegal   = illegal_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: a small datapath model executes the sequencer's controls; a monitor checks
// each completed instruction against hand-computed expectations queued by the stimulus.
module tb_alu_control_sequencer;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir_q;
    logic        PCout, ZLowout, ZHighout, MDRout, Rout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin, read;
    logic [3:0]  ALU_operation, reg_select;
    logic        busy, instr_done, illegal, mem_fault;

    alu_control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .run(run), .IR(ir_q), .mem_ready(mem_ready),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Rin(Rin), .HIin(HIin), .LOin(LOin), .read(read), .ALU_operation(ALU_operation),
        .reg_select(reg_select), .busy(busy), .instr_done(instr_done), .illegal(illegal),
        .mem_fault(mem_fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- datapath model ----------------
    logic [31:0] mem_word;
    logic [31:0] pc_q, mar_q, mdr_q, y_q, hi_q, lo_q, bus;
    logic [63:0] z_q;
    logic [31:0] rf [16];
    logic [15:0] enables;

    assign enables = {PCout, ZLowout, ZHighout, MDRout, Rout, PCin, MARin, MDRin, IRin, Yin,
                      Zin, Rin, HIin, LOin, read, instr_done};

    always_comb begin
        bus = 32'd0;
        if (PCout)         bus = pc_q;
        else if (ZLowout)  bus = z_q[31:0];
        else if (ZHighout) bus = z_q[63:32];
        else if (MDRout)   bus = mdr_q;
        else if (Rout)     bus = rf[reg_select];
    end

    function automatic logic [63:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            4'd0:  return {32'd0, a + b};
            4'd1:  return {32'd0, a - b};
            4'd2:  return {32'd0, a & b};
            4'd3:  return {32'd0, a | b};
            4'd4:  return {32'd0, 32'd0 - b};
            4'd5:  return {32'd0, ~b};
            4'd11: return {32'd0, a} * {32'd0, b};
            4'd12: return (b == 0) ? 64'd0 : {a % b, a / b};
            4'd13: return {32'd0, b + 32'd1};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_q <= 0; mar_q <= 0; mdr_q <= 0; y_q <= 0; z_q <= 0; hi_q <= 0; lo_q <= 0;
            ir_q <= 0;
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[5] <= 32'h34;
            rf[6] <= 32'h45;
        end else begin
            if (PCin)  pc_q  <= bus;
            if (MARin) mar_q <= bus;
            if (MDRin && read && mem_ready) mdr_q <= mem_word;
            if (IRin)  ir_q  <= bus;
            if (Yin)   y_q   <= bus;
            if (Zin)   z_q   <= alu(ALU_operation, y_q, bus);
            if (Rin)   rf[reg_select] <= bus;
            if (HIin)  hi_q  <= bus;
            if (LOin)  lo_q  <= bus;
        end
    end

    // Memory responder: asserts mem_ready after `waits` non-ready read cycles.
    int waits = 0;
    int rd_cycles = 0;
    initial mem_ready = 1'b0;
    always @(negedge clock) begin
        if (read) begin
            mem_ready = (rd_cycles >= waits);
            rd_cycles++;
        end else begin
            mem_ready = 1'b0;
            rd_cycles = 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          lat;
        int          pcin;
        logic [11:0] rsel;
        logic [3:0]  op;
        int          rin;
        logic [31:0] wval;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;
    exp_t sb[$];

    int          m_cyc, m_pcin, m_rin;
    logic [11:0] m_rsel;
    logic [3:0]  m_op;
    logic [31:0] m_wval, m_lo, m_hi;
    bit          m_active = 0;

    always @(negedge clock) begin
        if (clear) begin
            m_active = 0;
        end else begin
            if (PCout && MARin) begin
                m_cyc = 0; m_pcin = 0; m_rin = 0; m_rsel = 0; m_op = 4'd14;
                m_wval = 0; m_lo = 0; m_hi = 0; m_active = 1;
            end
            if (m_active) begin
                m_cyc++;
                if (PCin) m_pcin++;
                if (Rout && Yin) m_rsel[11:8] = reg_select;
                if (Rout && Zin) begin
                    m_rsel[7:4] = reg_select;
                    m_op = ALU_operation;
                end
                if (Rin) begin
                    m_rsel[3:0] = reg_select;
                    m_rin++;
                    m_wval = bus;
                end
                if (LOin) m_lo = bus;
                if (HIin) m_hi = bus;
            end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_instr_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_latency"}, m_cyc, e.lat);
                    check({e.name, "_pcin_count"}, m_pcin, e.pcin);
                    check({e.name, "_reg_select_seq"}, m_rsel, e.rsel);
                    check({e.name, "_alu_op"}, m_op, e.op);
                    check({e.name, "_rin_count"}, m_rin, e.rin);
                    check({e.name, "_write_value"}, m_wval, e.wval);
                    check({e.name, "_lo"}, m_lo, e.lo);
                    check({e.name, "_hi"}, m_hi, e.hi);
                end
                m_active = 0;
            end
        end
    end

    function automatic void push_exp(input string name, input int lat, input logic [11:0] rsel,
                                     input logic [3:0] op, input int rin, input logic [31:0] wval,
                                     input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.name = name; e.lat = lat; e.pcin = 1; e.rsel = rsel; e.op = op; e.rin = rin;
        e.wval = wval; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_t0(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!(PCout && MARin) && cycles < 30);
        if (!(PCout && MARin)) check({name, "_t0_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!instr_done && c < 40);
        if (!instr_done) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_prog(input string name, input logic [31:0] word, input int waits_i,
                            input int n);
        int gap;
        mem_word = word;
        waits    = waits_i;
        run      = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_t0(name, gap);
            if (i > 0) check({name, "_b2b_gap"}, gap, 1);
            if (i == n - 1) run = 1'b0;
            wait_done(name);
        end
        @(negedge clock);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_enables"}, enables, 16'd0);
        check({name, "_alu_op"}, ALU_operation, 4'd14);
        check({name, "_reg_select"}, reg_select, 4'd0);
        check({name, "_flags"}, {busy, illegal, mem_fault}, 3'b000);
    endtask

    initial begin
        int c;
        clear    = 1'b1;
        run      = 1'b0;
        mem_word = 32'd0;
        #1;
        check_reset_state("reset");
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;

        push_exp("and", 6, 12'h562, 4'd2, 1, 32'h04, 0, 0);
        run_prog("and", 32'h112B0000, 0, 1);
        check("and_r2", rf[2], 32'h04);

        push_exp("sub_w3", 9, 12'h562, 4'd1, 1, 32'hFFFFFFEF, 0, 0);
        run_prog("sub_w3", 32'h092B0000, 3, 1);
        check("sub_w3_r2", rf[2], 32'hFFFFFFEF);

        push_exp("mul", 7, 12'h560, 4'd11, 0, 0, 32'h00000E04, 0);
        run_prog("mul", 32'h582B0000, 0, 1);
        check("mul_lo_reg", lo_q, 32'h00000E04);

        push_exp("sub_w15", 21, 12'h562, 4'd1, 1, 32'hFFFFFFEF, 0, 0);
        run_prog("sub_w15", 32'h092B0000, 15, 1);

        push_exp("b2b_0", 6, 12'h562, 4'd2, 1, 32'h04, 0, 0);
        push_exp("b2b_1", 6, 12'h562, 4'd2, 1, 32'h04, 0, 0);
        run_prog("b2b", 32'h112B0000, 0, 2);

        // Asynchronous clear in the middle of T4, then restart.
        mem_word = 32'h112B0000;
        waits    = 0;
        run      = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!(Rout && Zin) && c < 30);
        check("clr_reach_t4", Rout && Zin, 1'b1);
        #1 clear = 1'b1;
        #1 check_reset_state("clr_t4");
        @(negedge clock);
        @(negedge clock);
        push_exp("after_clr", 6, 12'h562, 4'd2, 1, 32'h04, 0, 0);
        clear = 1'b0;
        @(negedge clock);
        check("after_clr_t0", {PCout, MARin, busy}, 3'b111);
        run = 1'b0;
        wait_done("after_clr");
        @(negedge clock);

        // Illegal opcode halts after T3.
        mem_word = 32'hF8000000;
        run      = 1'b1;
        wait_t0("illegal", c);
        repeat (3) @(negedge clock);
        check("illegal_t3_quiet", {enables, busy}, {16'd0, 1'b1});
        @(negedge clock);
        check("illegal_halt", {busy, illegal, mem_fault}, 3'b010);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            @(negedge clock);
        end
        check("illegal_sticky", {busy, illegal, mem_fault, enables}, {3'b010, 16'd0});
        clear = 1'b1;
        run   = 1'b0;
        #1 check_reset_state("illegal_clr");
        @(negedge clock);
        clear = 1'b0;

        // Fetch timeout: T1 plus 15 T1W cycles without mem_ready.
        waits = 1000;
        run   = 1'b1;
        wait_t0("timeout", c);
        c = 0;
        do begin
            @(negedge clock);
            if (read) c++;
        end while (busy && c < 40);
        run = 1'b0;
        check("timeout_read_cycles", c, 16);
        check("timeout_halt", {busy, illegal, mem_fault}, 3'b001);
        @(negedge clock);
        check("timeout_sticky", {busy, illegal, mem_fault}, 3'b001);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
